// File: rtl/char_rom_arbiter_pkg.sv
// Shared constants and types for the character ROM arbiter.
package char_rom_arb_pkg;
   localparam int N_REQ     = 3;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 7;
   localparam int MAX_BURST = 16;
   localparam int OWNER_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W     = 8;

   typedef logic [OWNER_W-1:0] owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } pipe_stage_t;

   typedef enum logic {IDLE, BURST} burst_st_t;
endpackage

// File: rtl/char_rom_arbiter_if.sv
// Requester-side bus: requests, burst hints, addresses, grants and returned codes.
interface char_rom_arbiter_if;
   import char_rom_arb_pkg::*;

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        lock;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]       rdata;

   modport master (output req, lock, addr, input gnt, rvalid, rdata);
   modport slave  (input req, lock, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/char_rom_arbiter_rr.sv
// Round-robin picker: first asserted request strictly after 'last', wrapping.
module rr_picker
   import char_rom_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  owner_t           last,
   output logic [N_REQ-1:0] gnt,
   output owner_t           idx,
   output logic             any
);
   // Scan last+1 .. last+N_REQ (mod N_REQ); the first hit wins.
   always_comb begin
      owner_t j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = owner_t'((int'(last) + k) % N_REQ);
         if (!any && req[j]) begin
            any = 1'b1;
            idx = j;
         end
      end
      if (any) gnt[idx] = 1'b1;
   end
endmodule

// File: rtl/char_rom_arbiter.sv
// Shares one registered character ROM between requesters: RR arbitration,
// limited locked bursts, and a 2-stage owner pipeline matching ROM latency.
module char_rom_arbiter
   import char_rom_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   char_rom_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] char_xy,
   input  logic [DATA_W-1:0] char_code
);
   burst_st_t        st, st_nxt;
   owner_t           burst_owner, owner_nxt;
   logic [CNT_W-1:0] burst_cnt, cnt_nxt;
   owner_t           last, win, pick_idx;
   logic [N_REQ-1:0] pick_gnt, others;
   logic             pick_any, hold, win_any;
   pipe_stage_t      s1, s2;

   rr_picker u_pick (
      .req  (bus.req),
      .last (last),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // Keep the burst owner unless it let go or hit the limit with others waiting.
   always_comb begin
      others              = bus.req;
      others[burst_owner] = 1'b0;
      hold    = (st == BURST) && bus.req[burst_owner] && bus.lock[burst_owner]
                && !((burst_cnt >= CNT_W'(MAX_BURST)) && (|others));
      win_any = !rst && (hold || pick_any);
      win     = hold ? burst_owner : pick_idx;
   end

   // Burst FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= IDLE;
         burst_owner <= '0;
         burst_cnt   <= '0;
      end else begin
         st          <= st_nxt;
         burst_owner <= owner_nxt;
         burst_cnt   <= cnt_nxt;
      end
   end

   // Burst FSM next state: a locked winner opens or extends a burst.
   always_comb begin
      st_nxt    = IDLE;
      owner_nxt = '0;
      cnt_nxt   = '0;
      if (win_any && bus.lock[win]) begin
         st_nxt    = BURST;
         owner_nxt = win;
         if (st == BURST && win == burst_owner)
            cnt_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
         else
            cnt_nxt = CNT_W'(1);
      end
   end

   // Outputs: grant for this cycle, and ROM data routed to the stage-2 owner.
   always_comb begin
      bus.gnt    = '0;
      bus.rvalid = '0;
      bus.rdata  = '0;
      if (win_any) bus.gnt = hold ? (N_REQ'(1) << burst_owner) : pick_gnt;
      if (s2.valid) begin
         bus.rvalid[s2.owner] = 1'b1;
         bus.rdata            = char_code;
      end
   end

   // Address register, RR pointer and owner pipeline tracking ROM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         char_xy <= '0;
         last    <= owner_t'(N_REQ - 1);
         s1      <= '0;
         s2      <= '0;
      end else begin
         s2       <= s1;
         s1.valid <= win_any;
         s1.owner <= win;
         if (win_any) begin
            char_xy <= bus.addr[int'(win)*ADDR_W +: ADDR_W];
            last    <= win;
         end
      end
   end
endmodule

// File: tb/tb_char_rom_arbiter.sv
// Bench for char_rom_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_char_rom_arbiter;
   import char_rom_arb_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] char_xy;
   logic [DATA_W-1:0] char_code;

   char_rom_arbiter_if bus();

   char_rom_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .char_xy   (char_xy),
      .char_code (char_code)
   );

   always #5 clk = ~clk;

   // Registered ROM model
   logic [DATA_W-1:0] rom [256];
   always @(posedge clk) char_code <= rom[char_xy];

   int errs = 0, checks = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   bit                mon_on = 0;
   int                m_last = N_REQ - 1, m_owner = -1, m_cnt = 0;
   bit                p1v = 0, p2v = 0;
   int                p1o = 0, p2o = 0;
   logic [ADDR_W-1:0] p1a = '0, p2a = '0, m_xy = '0;
   logic [N_REQ-1:0]  gnt_seen = '0;
   int                g_log[$], rvo_log[$], e_log[$];
   logic [DATA_W-1:0] r_log[$];

   always @(negedge clk) begin
      int w;
      bit other;
      logic [N_REQ-1:0]  eg, ev;
      logic [DATA_W-1:0] ed;
      gnt_seen = bus.gnt;
      if (mon_on) begin
         w = -1;
         other = 0;
         for (int j = 0; j < N_REQ; j++) if (bus.req[j] && j != m_owner) other = 1;
         if (!rst) begin
            if (m_owner >= 0 && bus.req[m_owner] && bus.lock[m_owner] &&
                !(m_cnt >= MAX_BURST && other))
               w = m_owner;
            else
               for (int k = 1; k <= N_REQ; k++)
                  if (w < 0 && bus.req[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
         end
         eg = (w >= 0) ? N_REQ'(1 << w) : '0;
         ev = p2v ? N_REQ'(1 << p2o) : '0;
         ed = p2v ? rom[p2a] : '0;
         chk("gnt", bus.gnt, eg);
         chk("rvalid", bus.rvalid, ev);
         chk("rdata", bus.rdata, ed);
         chk("char_xy", char_xy, m_xy);
         for (int j = 0; j < N_REQ; j++) begin
            if (bus.gnt[j]) g_log.push_back(j);
            if (bus.rvalid[j]) begin
               rvo_log.push_back(j);
               r_log.push_back(bus.rdata);
            end
         end
         if (rst) begin
            m_last = N_REQ - 1; m_owner = -1; m_cnt = 0;
            p1v = 0; p2v = 0; m_xy = '0;
         end else begin
            p2v = p1v; p2o = p1o; p2a = p1a;
            p1v = (w >= 0);
            if (w >= 0) begin
               p1o = w;
               p1a = bus.addr[w*ADDR_W +: ADDR_W];
               m_xy = p1a;
               m_last = w;
               if (bus.lock[w]) begin
                  if (w == m_owner) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                  else begin m_owner = w; m_cnt = 1; end
               end else begin
                  m_owner = -1; m_cnt = 0;
               end
            end else begin
               m_owner = -1; m_cnt = 0;
            end
         end
      end
   end

   // Requester drivers: each holds a count of reads, an address and lock hint
   int                rem [N_REQ];
   logic [ADDR_W-1:0] na  [N_REQ];
   bit                lk  [N_REQ];
   bit                inc [N_REQ];

   task automatic apply();
      for (int i = 0; i < N_REQ; i++) begin
         bus.req[i]  = (rem[i] > 0);
         bus.lock[i] = lk[i] && (rem[i] > 0);
         bus.addr[i*ADDR_W +: ADDR_W] = na[i];
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      for (int i = 0; i < N_REQ; i++)
         if (gnt_seen[i]) begin
            rem[i]--;
            if (inc[i]) na[i]++;
         end
      apply();
   endtask

   task automatic load(int i, int n, logic [ADDR_W-1:0] a, bit l, bit ic);
      rem[i] = n; na[i] = a; lk[i] = l; inc[i] = ic;
      apply();
   endtask

   task automatic do_reset(int n);
      rst = 1'b1;
      for (int i = 0; i < N_REQ; i++) rem[i] = 0;
      apply();
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic clr();
      g_log.delete(); rvo_log.delete(); r_log.delete(); e_log.delete();
   endtask

   task automatic cmp_gnt(string tag);
      chk({tag, "_ngnt"}, g_log.size(), e_log.size());
      for (int i = 0; i < e_log.size(); i++)
         chk({tag, "_gnt_seq"}, (i < g_log.size()) ? g_log[i] : -1, e_log[i]);
   endtask

   task automatic cmp_rv(string tag);
      chk({tag, "_nrv"}, rvo_log.size(), e_log.size());
      for (int i = 0; i < e_log.size(); i++)
         chk({tag, "_rv_seq"}, (i < rvo_log.size()) ? rvo_log[i] : -1, e_log[i]);
   endtask

   // Locked requester 0 for 20 reads, requester 2 joins one cycle later.
   task automatic t_limit(string tag);
      clr();
      load(0, 20, 8'h40, 1, 1);
      step();
      load(2, 1, 8'h80, 0, 0);
      repeat (25) step();
      for (int k = 0; k < 16; k++) e_log.push_back(0);
      e_log.push_back(2);
      for (int k = 0; k < 4; k++) e_log.push_back(0);
      cmp_gnt(tag);
      cmp_rv(tag);
   endtask

   initial begin
      string s;
      byte   b;
      s = "POZDRAWIAM";
      for (int i = 0; i < 256; i++) rom[i] = DATA_W'($urandom_range(32, 126));
      rom[0] = 7'h57;
      for (int i = 0; i < 10; i++) begin
         b = s[i];
         rom[8'hd0 + i] = b[6:0];
      end
      for (int i = 0; i < N_REQ; i++) begin rem[i] = 0; na[i] = '0; lk[i] = 0; inc[i] = 0; end
      apply();

      // Reset
      @(posedge clk); #1;
      mon_on = 1;
      step(); step();
      rst = 1'b0;
      chk("reset_xy", char_xy, 0);
      chk("reset_rvalid", bus.rvalid, 0);

      // Single read of address 0
      clr();
      load(0, 1, 8'h00, 0, 0);
      repeat (4) step();
      e_log.push_back(0);
      cmp_gnt("t1");
      chk("t1_rdata", (r_log.size() > 0) ? r_log[0] : 7'h7f, 7'h57);

      // Plain round robin, three requesters two reads each
      do_reset(2);
      clr();
      for (int i = 0; i < N_REQ; i++) load(i, 2, 8'h10 + ADDR_W'(i), 0, 0);
      repeat (9) step();
      for (int k = 0; k < 6; k++) e_log.push_back(k % 3);
      cmp_gnt("t2");
      cmp_rv("t2");

      // Locked 10-character stream from requester 1
      clr();
      load(1, 10, 8'hd0, 1, 1);
      repeat (13) step();
      for (int k = 0; k < 10; k++) e_log.push_back(1);
      cmp_gnt("t3");
      chk("t3_nrd", r_log.size(), 10);
      for (int i = 0; i < 10; i++) begin
         b = s[i];
         chk("t3_text", (i < r_log.size()) ? r_log[i] : 7'h7f, b[6:0]);
      end

      // Burst limit
      t_limit("t4");

      // Short burst, idle gap, then the limit pattern again from a fresh count
      clr();
      load(0, 5, 8'h20, 1, 1);
      repeat (5) step();
      repeat (3) step();
      t_limit("t6");

      // Reset with two reads in flight
      clr();
      load(0, 4, 8'h30, 0, 1);
      step(); step();
      rst = 1'b1;
      rem[0] = 0;
      apply();
      step();
      clr();
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("t5_no_rvalid", r_log.size(), 0);
      chk("t5_xy", char_xy, 0);
      clr();
      for (int i = 0; i < N_REQ; i++) load(i, 1, 8'h50 + ADDR_W'(i), 0, 0);
      repeat (5) step();
      for (int k = 0; k < 3; k++) e_log.push_back(k);
      cmp_gnt("t5");

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N_REQ; i++)
            if (rem[i] == 0 && $urandom_range(0, 3) == 0)
               load(i, $urandom_range(1, 20), ADDR_W'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step();
         if ($urandom_range(0, 149) == 0) begin
            rst = 1'b1;
            for (int i = 0; i < N_REQ; i++) rem[i] = 0;
            apply();
            step();
            rst = 1'b0;
         end
         clr();
      end
      for (int i = 0; i < N_REQ; i++) rem[i] = 0;
      apply();
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
